// File: rtl/inst_dispatcher_pkg.sv
// Shared definitions for the instruction dispatcher: instruction field layout, opcodes,
// per-opcode cycle budgets and FSM state type.
package inst_dispatcher_pkg;

   localparam int OPCODE_BITS = 4;
   localparam int ADDR_BITS   = 8;
   localparam int INST_WIDTH  = OPCODE_BITS + 2 * ADDR_BITS;

   localparam int OPCODE_FROM = INST_WIDTH - 1;
   localparam int OPCODE_TO   = 2 * ADDR_BITS;
   localparam int ADDRA_FROM  = 2 * ADDR_BITS - 1;
   localparam int ADDRA_TO    = ADDR_BITS;
   localparam int ADDRB_FROM  = ADDR_BITS - 1;
   localparam int ADDRB_TO    = 0;

   typedef logic [OPCODE_BITS-1:0] opcode_t;

   localparam opcode_t IDLE_OP              = 4'd0;
   localparam opcode_t AXI_TO_UB_OP         = 4'd1;
   localparam opcode_t AXI_TO_WB_OP         = 4'd2;
   localparam opcode_t UB_TO_DATA_FIFO_OP   = 4'd3;
   localparam opcode_t UB_TO_WEIGHT_FIFO_OP = 4'd4;
   localparam opcode_t MAT_MUL_OP           = 4'd5;
   localparam opcode_t MAT_MUL_ACC_OP       = 4'd6;
   localparam opcode_t ACC_TO_UB_OP         = 4'd7;
   localparam opcode_t UB_TO_AXI_OP         = 4'd8;

   localparam logic [INST_WIDTH-1:0] IDLE_INST = {IDLE_OP, {(2 * ADDR_BITS){1'b0}}};

   localparam int BUDGET_BITS             = 8;
   localparam int IDLE_CYCLE              = 1;
   localparam int UB_TO_DATA_FIFO_CYCLE   = 4;
   localparam int UB_TO_WEIGHT_FIFO_CYCLE = 6;
   localparam int MAT_MUL_CYCLE           = 12;
   localparam int ACC_TO_UB_CYCLE         = 5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COUNT,
      S_WAIT_LO,
      S_WAIT_HI
   } state_t;

   function automatic logic is_axi_op(input opcode_t op);
      return op inside {AXI_TO_UB_OP, AXI_TO_WB_OP, UB_TO_AXI_OP};
   endfunction

   // Unknown opcodes get a single hold cycle so the queue never stalls on them.
   function automatic logic [BUDGET_BITS-1:0] op_budget(input opcode_t op);
      case (op)
         IDLE_OP:                    return BUDGET_BITS'(IDLE_CYCLE);
         UB_TO_DATA_FIFO_OP:         return BUDGET_BITS'(UB_TO_DATA_FIFO_CYCLE);
         UB_TO_WEIGHT_FIFO_OP:       return BUDGET_BITS'(UB_TO_WEIGHT_FIFO_CYCLE);
         MAT_MUL_OP, MAT_MUL_ACC_OP: return BUDGET_BITS'(MAT_MUL_CYCLE);
         ACC_TO_UB_OP:               return BUDGET_BITS'(ACC_TO_UB_CYCLE);
         default:                    return BUDGET_BITS'(1);
      endcase
   endfunction

endpackage

// File: rtl/inst_dispatcher_if.sv
// Host push channel plus the instruction/flag link to the systolic array.
interface inst_dispatcher_if
   import inst_dispatcher_pkg::*;
#(
   parameter int INST_BITS = INST_WIDTH
);
   logic [INST_BITS-1:0] in_inst;
   logic                 in_valid;
   logic                 in_ready;
   logic [INST_BITS-1:0] instruction;
   logic                 flag;

   modport master (
      output in_inst, in_valid, flag,
      input  in_ready, instruction
   );

   modport slave (
      input  in_inst, in_valid, flag,
      output in_ready, instruction
   );
endinterface

// File: rtl/inst_dispatcher_fifo.sv
// Synchronous instruction queue: registered full/empty flags, head word read straight
// from the storage array so a pop and its data land on the same edge.
module inst_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]      count_reg, count_next;
   logic             full_reg, empty_reg;
   logic             do_push, do_pop;

   assign do_push = push && !full_reg;
   assign do_pop  = pop && !empty_reg;

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + (AW+1)'(1);
         2'b01:   count_next = count_reg - (AW+1)'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_next;
         full_reg  <= (count_next == (AW+1)'(DEPTH));
         empty_reg <= (count_next == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= wr_data;
   end

   assign rd_data = mem[rd_ptr_reg];
   assign full    = full_reg;
   assign empty   = empty_reg;
endmodule

// File: rtl/inst_dispatcher.sv
// Queues host instructions and issues them to the systolic array one at a time.
// Optional flag-wait watchdog enabled by defining INST_DISPATCH_TIMEOUT_EN.
module inst_dispatcher
   import inst_dispatcher_pkg::*;
#(
   parameter int INST_BITS  = INST_WIDTH,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_BITS   = 16
`ifdef INST_DISPATCH_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 4096
`endif
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                run,
   inst_dispatcher_if.slave    bus,
   output logic                busy,
   output logic                done,
   output logic [CNT_BITS-1:0] issued_cnt,
   output logic                err
);
   logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [INST_BITS-1:0]   head;
   opcode_t                head_op;

   state_t                 state_reg, state_next;
   logic [BUDGET_BITS-1:0] cnt_reg, cnt_next;
   logic [INST_BITS-1:0]   inst_reg, inst_next;
   logic                   done_reg, done_next;
   logic [CNT_BITS-1:0]    issued_reg, issued_next;
   logic                   load, finish;

   assign fifo_push    = bus.in_valid && !fifo_full;
   assign bus.in_ready = !fifo_full;
   assign head_op      = head[OPCODE_FROM:OPCODE_TO];

   inst_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INST_BITS)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .wr_data (bus.in_inst),
      .pop     (fifo_pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef INST_DISPATCH_TIMEOUT_EN
   localparam int WD_BITS = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [WD_BITS-1:0] wd_reg, wd_next;
   logic               err_reg, err_next;
   logic               waiting, timeout;

   assign waiting = (state_reg == S_WAIT_LO) || (state_reg == S_WAIT_HI);
   assign timeout = waiting && (wd_reg == WD_BITS'(TIMEOUT_CYC - 1));
   assign err     = err_reg;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      inst_next   = inst_reg;
      done_next   = 1'b0;
      issued_next = issued_reg;
      load        = 1'b0;
      finish      = 1'b0;
      fifo_pop    = 1'b0;
`ifdef INST_DISPATCH_TIMEOUT_EN
      wd_next  = waiting ? wd_reg + WD_BITS'(1) : '0;
      err_next = err_reg;
`endif

      case (state_reg)
         S_IDLE:    load = run && !fifo_empty;
         S_COUNT:   if (cnt_reg == '0) finish = 1'b1;
                    else cnt_next = cnt_reg - BUDGET_BITS'(1);
         S_WAIT_LO: if (!bus.flag) state_next = S_WAIT_HI;
         S_WAIT_HI: if (bus.flag) finish = 1'b1;
         default:   state_next = S_IDLE;
      endcase

      // Retiring with work queued chains straight into the next instruction.
      if (finish) begin
         done_next   = 1'b1;
         issued_next = issued_reg + CNT_BITS'(1);
         load        = run && !fifo_empty;
         if (!load) begin
            inst_next  = INST_BITS'(IDLE_INST);
            state_next = S_IDLE;
         end
      end

`ifdef INST_DISPATCH_TIMEOUT_EN
      // A stalled handshake is abandoned without retiring; the queue resumes from S_IDLE.
      if (timeout && !finish) begin
         err_next   = 1'b1;
         inst_next  = INST_BITS'(IDLE_INST);
         state_next = S_IDLE;
      end
      if (load) wd_next = '0;
`endif

      if (load) begin
         fifo_pop  = 1'b1;
         inst_next = head;
         if (is_axi_op(head_op)) begin
            state_next = S_WAIT_LO;
         end else begin
            state_next = S_COUNT;
            cnt_next   = op_budget(head_op) - BUDGET_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         inst_reg   <= INST_BITS'(IDLE_INST);
         done_reg   <= 1'b0;
         issued_reg <= '0;
`ifdef INST_DISPATCH_TIMEOUT_EN
         wd_reg     <= '0;
         err_reg    <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         inst_reg   <= inst_next;
         done_reg   <= done_next;
         issued_reg <= issued_next;
`ifdef INST_DISPATCH_TIMEOUT_EN
         wd_reg     <= wd_next;
         err_reg    <= err_next;
`endif
      end
   end

   assign bus.instruction = inst_reg;
   assign done            = done_reg;
   assign issued_cnt      = issued_reg;
   assign busy            = (state_reg != S_IDLE) || !fifo_empty;
endmodule
